// File: rtl/bram_if_pkg.sv
// Shared constants and request encoding for BRAM port masters and their clients.
package bram_if_pkg;

  localparam int DEF_DATA_W = 36;
  localparam int DEF_ADDR_W = 9;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } req_kind_e;

endpackage

// File: rtl/bram_resp_fifo.sv
// Response buffer: power-of-two ring with wrapping pointers and a separate occupancy count.
module bram_resp_fifo #(
  parameter int width = 36,
  parameter int depth = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [width-1:0] wdata,
  input  logic             pop,
  output logic [width-1:0] rdata,
  output logic             empty
);

  localparam int PTR_W = $clog2(depth);
  localparam int CNT_W = PTR_W + 1;

  logic [width-1:0] mem [depth];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(depth));
  assign do_pop  = pop & ~empty;
  // A push into a full buffer is fine when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/bram_port_master.sv
// Credit-flow master for one BRAM port with an in-order read response buffer.
// Define BRAM_PORT_MASTER_BYPASS_EN to forward a capture straight to resp_* when the buffer is empty.
module bram_port_master
  import bram_if_pkg::*;
#(
  parameter int dataWidth = DEF_DATA_W,
  parameter int addrWidth = DEF_ADDR_W,
  parameter int respDepth = 2
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [addrWidth-1:0] req_addr,
  input  logic [dataWidth-1:0] req_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [dataWidth-1:0] resp_data,
  output logic                 bram_en,
  output logic                 bram_we,
  output logic [addrWidth-1:0] bram_addr,
  output logic [dataWidth-1:0] bram_di,
  input  logic [dataWidth-1:0] bram_do,
  input  logic                 bram_rdy,
  input  logic                 bram_rdyResp
);

  localparam int CRED_W = $clog2(respDepth) + 1;

  logic                 run;
  logic                 inflight;
  logic [CRED_W-1:0]    credits;
  logic                 is_wr;
  logic                 stall;
  logic                 capture;
  logic                 accept;
  logic                 read_acc;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [dataWidth-1:0] fifo_rdata;

  assign is_wr    = (req_kind_e'(req_write) == REQ_WRITE);
  // Holding off new requests while a read waits keeps the BRAM output register stable.
  assign stall    = inflight & ~bram_rdyResp;
  assign capture  = inflight & bram_rdyResp;
  assign req_ready = run & bram_rdy & ~stall & (is_wr | (credits != '0));
  assign accept   = req_valid & req_ready;
  assign read_acc = accept & ~is_wr;

  assign bram_en   = accept;
  assign bram_we   = accept & is_wr;
  assign bram_addr = req_addr;
  assign bram_di   = req_data;

`ifdef BRAM_PORT_MASTER_BYPASS_EN
  assign resp_valid = ~fifo_empty | capture;
  assign resp_data  = fifo_empty ? bram_do : fifo_rdata;
  assign push       = capture & ~(fifo_empty & resp_ready);
`else
  assign resp_valid = ~fifo_empty;
  assign resp_data  = fifo_rdata;
  assign push       = capture;
`endif

  assign pop = resp_valid & resp_ready;

  // run gates req_ready so it cannot rise before the first edge after reset release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      run      <= 1'b0;
      inflight <= 1'b0;
      credits  <= CRED_W'(respDepth);
    end else begin
      run <= 1'b1;
      if (read_acc)     inflight <= 1'b1;
      else if (capture) inflight <= 1'b0;
      case ({read_acc, pop})
        2'b10:   credits <= credits - CRED_W'(1);
        2'b01:   credits <= credits + CRED_W'(1);
        default: credits <= credits;
      endcase
    end
  end

  bram_resp_fifo #(
    .width (dataWidth),
    .depth (respDepth)
  ) u_resp_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (push),
    .wdata (bram_do),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_bram_port_master.sv
// Directed bench for bram_port_master with a 1-cycle-latency BRAM model.
module tb_bram_port_master;

  localparam int DW = 36;
  localparam int AW = 9;
  localparam int RD = 2;
`ifdef BRAM_PORT_MASTER_BYPASS_EN
  localparam int LAT_EXTRA = 0;
`else
  localparam int LAT_EXTRA = 1;
`endif

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_data;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_di, bram_do;
  logic          bram_rdy, bram_rdyResp;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] do_q = '0;
  always @(posedge CLK) begin
    if (bram_en) begin
      if (bram_we) mem[bram_addr] <= bram_di;
      else         do_q <= mem[bram_addr];
    end
  end
  assign bram_do = do_q;

  bram_port_master #(.dataWidth(DW), .addrWidth(AW), .respDepth(RD)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_di(bram_di),
    .bram_do(bram_do), .bram_rdy(bram_rdy), .bram_rdyResp(bram_rdyResp)
  );

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
  endtask

  task automatic drive_read(input logic [AW-1:0] a);
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_data = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_data = d;
    #1;
    total++;
    if (!(bram_en === 1'b1 && bram_we === 1'b1 && bram_addr === a && bram_di === d)) begin
      bad++;
      $display("FAIL preload_wr addr=%0d got en=%b we=%b di=%h want en=1 we=1 di=%h", a, bram_en, bram_we, bram_di, d);
    end
    step(); idle();
  endtask

  task automatic test_reset();
    bram_rdy = 1'b1; bram_rdyResp = 1'b1; resp_ready = 1'b0;
    drive_read(9'd1);
    step(); step(); #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", req_ready); end
    total++; if (bram_en !== 1'b0 || bram_we !== 1'b0) begin bad++; $display("FAIL rst_bram got en=%b we=%b want 0 0", bram_en, bram_we); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b want=0", resp_valid); end
    total++; if (dut.credits !== 2'd2) begin bad++; $display("FAIL rst_credits got=%0d want=2", dut.credits); end
    total++; if (dut.inflight !== 1'b0) begin bad++; $display("FAIL rst_inflight got=%b want=0", dut.inflight); end
    idle();
    RST_N = 1'b1; #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_release_ready got=%b want=0", req_ready); end
    step(); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_write_read();
    int nvalid = 0;
    int first_i = -1;
    logic [DW-1:0] got = '0;
    do_write(9'd3, 36'h5);
    drive_read(9'd3); #1;
    total++; if (req_ready !== 1'b1 || bram_en !== 1'b1 || bram_we !== 1'b0 || bram_addr !== 9'd3) begin
      bad++; $display("FAIL wr_rd_read_issue got rdy=%b en=%b we=%b addr=%0d want 1 1 0 3", req_ready, bram_en, bram_we, bram_addr);
    end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL wr_no_resp got=%b want=0", resp_valid); end
    step(); idle(); resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (resp_valid === 1'b1) begin
        nvalid++;
        if (first_i < 0) first_i = i;
        got = resp_data;
      end
      step();
    end
    total++; if (nvalid != 1) begin bad++; $display("FAIL wr_rd_resp_count got=%0d want=1", nvalid); end
    total++; if (first_i != LAT_EXTRA) begin bad++; $display("FAIL wr_rd_latency got=%0d want=%0d", first_i, LAT_EXTRA); end
    total++; if (got !== 36'h5) begin bad++; $display("FAIL wr_rd_data got=%h want=5", got); end
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int first_i = -1;
    logic [DW-1:0] got = '0;
    do_write(9'd10, 36'hA1);
    do_write(9'd11, 36'hA2);
    do_write(9'd12, 36'hA3);
    resp_ready = 1'b0;
    drive_read(9'd10); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_acc1 got=%b want=1", req_ready); end
    step();
    drive_read(9'd11); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_acc2 got=%b want=1", req_ready); end
    step();
    drive_read(9'd12);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (req_ready !== 1'b0 || bram_en !== 1'b0) begin
        bad++; $display("FAIL bp_block%0d got rdy=%b en=%b want 0 0", i, req_ready, bram_en);
      end
      step();
    end
    idle(); resp_ready = 1'b1; #1;
    total++; if (resp_valid !== 1'b1 || resp_data !== 36'hA1) begin bad++; $display("FAIL bp_resp1 got v=%b d=%h want 1 a1", resp_valid, resp_data); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_before_pop got=%b want=0", req_ready); end
    step(); #1;
    total++; if (resp_valid !== 1'b1 || resp_data !== 36'hA2) begin bad++; $display("FAIL bp_resp2 got v=%b d=%h want 1 a2", resp_valid, resp_data); end
    step();
    drive_read(9'd12); #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b want=0", resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_acc3 got=%b want=1", req_ready); end
    step(); idle();
    for (int i = 0; i < 5; i++) begin
      #1;
      if (resp_valid === 1'b1 && first_i < 0) begin first_i = i; got = resp_data; end
      step();
    end
    total++; if (first_i != LAT_EXTRA || got !== 36'hA3) begin bad++; $display("FAIL bp_resp3 got lat=%0d d=%h want lat=%0d d=a3", first_i, got, LAT_EXTRA); end
    resp_ready = 1'b0;
  endtask

  task automatic test_stall();
    int first_i = -1;
    logic [DW-1:0] got = '0;
    drive_read(9'd3); #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL stall_acc got=%b want=1", req_ready); end
    step();
    bram_rdyResp = 1'b0; drive_read(9'd10);
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (req_ready !== 1'b0 || bram_en !== 1'b0 || resp_valid !== 1'b0) begin
        bad++; $display("FAIL stall_hold%0d got rdy=%b en=%b v=%b want 0 0 0", i, req_ready, bram_en, resp_valid);
      end
      step();
    end
    bram_rdyResp = 1'b1; idle(); resp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (resp_valid === 1'b1 && first_i < 0) begin first_i = i; got = resp_data; end
      step();
    end
    total++; if (first_i != LAT_EXTRA || got !== 36'h5) begin bad++; $display("FAIL stall_capture got lat=%0d d=%h want lat=%0d d=5", first_i, got, LAT_EXTRA); end
    resp_ready = 1'b0;
  endtask

  task automatic test_bram_rdy();
    bram_rdy = 1'b0; drive_read(9'd3); #1;
    total++; if (req_ready !== 1'b0 || bram_en !== 1'b0) begin bad++; $display("FAIL nrdy_read got rdy=%b en=%b want 0 0", req_ready, bram_en); end
    req_write = 1'b1; req_data = 36'h77; #1;
    total++; if (req_ready !== 1'b0 || bram_en !== 1'b0 || bram_we !== 1'b0) begin bad++; $display("FAIL nrdy_write got rdy=%b en=%b we=%b want 0 0 0", req_ready, bram_en, bram_we); end
    step(); idle(); bram_rdy = 1'b1; #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL nrdy_recover got=%b want=1", req_ready); end
    step();
  endtask

  task automatic test_reset_midop();
    int leaked = 0;
    resp_ready = 1'b0;
    drive_read(9'd10); step();
    drive_read(9'd11); step();
    idle(); #1;
    total++; if (resp_valid !== 1'b1 || dut.inflight !== 1'b1) begin bad++; $display("FAIL mid_setup got v=%b inflight=%b want 1 1", resp_valid, dut.inflight); end
    RST_N = 1'b0; #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", resp_valid); end
    total++; if (dut.credits !== 2'd2) begin bad++; $display("FAIL mid_rst_credits got=%0d want=2", dut.credits); end
    total++; if (req_ready !== 1'b0 || dut.inflight !== 1'b0) begin bad++; $display("FAIL mid_rst_ctrl got rdy=%b inflight=%b want 0 0", req_ready, dut.inflight); end
    step(); RST_N = 1'b1; step();
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (resp_valid === 1'b1) leaked++;
      step();
    end
    total++; if (leaked != 0) begin bad++; $display("FAIL mid_rst_leak got=%0d want=0", leaked); end
    total++; if (dut.credits !== 2'd2) begin bad++; $display("FAIL mid_rst_credits_after got=%0d want=2", dut.credits); end
    resp_ready = 1'b0;
  endtask

  task automatic test_stream();
    int nxt = 22;
    int got = 0;
    int extra = 0;
    logic acc;
    for (int a = 20; a < 32; a++) do_write(AW'(a), DW'(36'h100 + a));
    resp_ready = 1'b0;
    drive_read(9'd20); step();
    drive_read(9'd21); step();
    idle(); step(); step(); #1;
    total++; if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin bad++; $display("FAIL stream_full got v=%b rdy=%b want 1 0", resp_valid, req_ready); end
    got = 0;
    for (int cyc = 0; cyc < 80 && !(got >= 12 && nxt > 31); cyc++) begin
      resp_ready = 1'b1;
      if (nxt <= 31) drive_read(AW'(nxt)); else idle();
      #1;
      acc = req_valid & req_ready;
      if (resp_valid === 1'b1) begin
        if (got < 12) begin
          total++;
          if (resp_data !== DW'(36'h100 + 20 + got)) begin
            bad++; $display("FAIL stream_data idx=%0d got=%h want=%h", got, resp_data, DW'(36'h100 + 20 + got));
          end
        end else extra++;
        got++;
      end
      step();
      if (acc) nxt++;
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      if (resp_valid === 1'b1) extra++;
      step();
    end
    total++; if (got != 12 || nxt != 32) begin bad++; $display("FAIL stream_count got resp=%0d next=%0d want 12 32", got, nxt); end
    total++; if (extra != 0) begin bad++; $display("FAIL stream_dup got=%0d want=0", extra); end
    resp_ready = 1'b0;
  endtask

  initial begin
    idle();
    test_reset();
    test_write_read();
    test_backpressure();
    test_stall();
    test_bram_rdy();
    test_reset_midop();
    test_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule

// File: doc/bram_port_master.md
BRAM_PORT_MASTER -- requirements
Module: bram_port_master

Interface
REQ-001 SHALL have parameter dataWidth, default 36: width of the data words.
REQ-002 SHALL have parameter addrWidth, default 9: width of the BRAM address.
REQ-003 SHALL have parameter respDepth, default 2: number of response FIFO entries (power of two, at least 2).
REQ-004 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1 bit: a client request is present.
REQ-007 SHALL have port req_ready, output, 1 bit: the block accepts the request this cycle.
REQ-008 SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port req_addr, input, addrWidth bits: request address.
REQ-010 SHALL have port req_data, input, dataWidth bits: write data.
REQ-011 SHALL have port resp_valid, output, 1 bit: read data is available.
REQ-012 SHALL have port resp_ready, input, 1 bit: the client consumes the response.
REQ-013 SHALL have port resp_data, output, dataWidth bits: read data.
REQ-014 SHALL have ports bram_en, bram_we (outputs, 1 bit), bram_addr (output, addrWidth bits) and bram_di (output, dataWidth bits): drive one BRAM port.
REQ-015 SHALL have ports bram_do (input, dataWidth bits), bram_rdy (input, 1 bit) and bram_rdyResp (input, 1 bit): BRAM read data, request-ready and response-ready.

Function
REQ-016 The block SHALL define accept as req_valid AND req_ready.
REQ-017 req_ready SHALL equal bram_rdy AND NOT stall AND (req_write OR credits != 0), where stall = inflight AND NOT bram_rdyResp.
REQ-018 On accept, in the same cycle, the block SHALL drive bram_en=1, bram_we=req_write, bram_addr=req_addr and bram_di=req_data (combinational pass-through).
REQ-019 When there is no accept, bram_en and bram_we SHALL be 0.
REQ-020 An accepted read SHALL set inflight for the following cycle; a write SHALL NOT set inflight and SHALL produce no response.
REQ-021 The BRAM read latency SHALL be 1 cycle.
REQ-022 bram_do SHALL be captured on the first cycle in which inflight AND bram_rdyResp; inflight SHALL then clear unless a new read is accepted in the same cycle.
REQ-023 While stall holds, no request SHALL be accepted, so the BRAM output register holds its value.
REQ-024 credits SHALL equal respDepth minus (FIFO occupancy plus in-flight reads).
REQ-025 credits SHALL decrement on a read accept and increment on a response pop; when both occur in one cycle, credits SHALL stay unchanged.
REQ-026 credits SHALL never underflow or overflow, and the FIFO SHALL never overflow.
REQ-027 resp_valid SHALL equal NOT fifo_empty (see REQ-035 for the bypass case).
REQ-028 A pop SHALL occur on resp_valid AND resp_ready; responses SHALL be returned in request order.
REQ-029 A simultaneous capture and pop on a full FIFO SHALL be legal, and occupancy SHALL stay unchanged.
REQ-030 FIFO read and write pointers SHALL be log2(respDepth) bits wide and wrap modulo respDepth, with a separate occupancy count.

Reset
REQ-031 Asserting RST_N low SHALL immediately force: credits=respDepth, FIFO empty, inflight=0, resp_valid=0, req_ready=0, bram_en=0, bram_we=0.
REQ-032 On reset mid-operation, in-flight reads and buffered responses SHALL be discarded without being delivered.
REQ-033 req_ready SHALL be permitted to rise from the first rising CLK edge after RST_N deasserts.

Configuration
REQ-034 The macro BRAM_PORT_MASTER_BYPASS_EN SHALL select response bypass.
REQ-035 With BRAM_PORT_MASTER_BYPASS_EN defined: when the FIFO is empty and a capture occurs, resp_valid=1 and resp_data=bram_do in that same cycle; if resp_ready=1, the data SHALL NOT be written to the FIFO. Accept-to-resp_valid latency is 1 cycle.
REQ-036 Without BRAM_PORT_MASTER_BYPASS_EN: every capture SHALL be written to the FIFO. Minimum accept-to-resp_valid latency is 2 cycles.

Structure
REQ-037 The shared package bram_if_pkg SHALL hold the default dataWidth/addrWidth constants and the read/write request encoding.
REQ-038 The response buffer SHALL be one sub-module, bram_resp_fifo (parameters: width, depth).

Verification
REQ-039 Write 0x5 to address 3, then read address 3 with resp_ready=1 SHALL return resp_data=0x5: 2 cycles after accept without bypass, 1 cycle with bypass; no response SHALL be produced for the write.
REQ-040 Three back-to-back reads with resp_ready=0 and respDepth=2 SHALL make req_ready fall after the 2nd accept; raising resp_ready SHALL deliver 2 responses in order, then the 3rd read SHALL be accepted.
REQ-041 A read accepted with bram_rdyResp=0 for 3 cycles SHALL hold req_ready=0 for those cycles; the capture SHALL occur on the cycle bram_rdyResp=1, with the correct data.
REQ-042 bram_rdy=0 with req_valid=1 SHALL produce req_ready=0 and bram_en=0.
REQ-043 RST_N pulsed low with one read in flight and one response buffered SHALL produce resp_valid=0 and credits=respDepth, and the old data SHALL never appear.
REQ-044 Full FIFO with simultaneous pop and a new read accept over 10 cycles SHALL produce a continuous stream with no loss or duplication.
